mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle RV64M multiply/divide unit in the execute stage, alongside the single-cycle ALU.
- Consumes operands from the issue side and returns one 64-bit result per operation.
- Valid/ready handshakes on both sides; one operation in flight; pipeline flush aborts it.
- Iterative: 1 result bit per cycle (shift-add multiply, restoring divide).

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- OP_W, 4, width of the op select.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- op  input  OP_W  operation: 0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- flush  input  1  abort the current operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- c  output  XLEN  result.

Behaviour:
- Reset (resetn low, async): state IDLE, in_ready=1, out_valid=0, c=0, all internal registers 0. Reset asserted mid-operation discards the operation.
- States and transitions:
  - IDLE: in_ready=1. Accept on in_valid&in_ready&!flush at edge T; latch op and a, b.
  - Special-case or unused op: go to DONE, so out_valid=1 in cycle T+1.
  - Otherwise go to BUSY with counter N: 64 for 64-bit ops, 32 for W ops.
  - BUSY: in_ready=0; one iteration per cycle. After N iterations go to DONE, so out_valid=1 in cycle T+N+1.
  - DONE: out_valid=1, c stable. On out_ready go to IDLE. A new request is accepted no earlier than the next cycle.
  - flush: from any state, go to IDLE at the next edge with out_valid=0. flush has priority over an accept and over an out handshake in the same cycle.
- W ops:
  - Operands are a[31:0] and b[31:0], sign-extended for MULW/DIVW/REMW and zero-extended for DIVUW/REMUW.
  - The 32-bit result is always sign-extended to 64 bits, DIVUW/REMUW included.
- MUL/MULW: low XLEN (respectively low 32) bits of the product. Signedness is irrelevant; no high-half ops.
- Signed divide:
  - Divide absolute values unsigned, then fix signs.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (b, or b[31:0] for W ops, equal to 0):
  - Quotient is all ones.
  - Remainder is the dividend, sign-extended for W ops.
  - Latency 1.
- Signed overflow (dividend = most negative value, divisor = -1, for the op's width):
  - Quotient is the dividend.
  - Remainder is 0.
  - Latency 1.
- Unused op codes (10-15): c=0, latency 1.
- c holds its last value whenever out_valid=0. Only its value while out_valid=1 is checked.

Test Plan:
1. MUL a=7, b=0xFFFF_FFFF_FFFF_FFFD, accepted at T -> out_valid at T+65, c=0xFFFF_FFFF_FFFF_FFEB; in_ready=0 in cycles T+1..T+65.
2. DIV a=-7, b=2 -> c=0xFFFF_FFFF_FFFF_FFFD at T+65. REM with the same operands -> c=0xFFFF_FFFF_FFFF_FFFF. DIVU a=100, b=7 -> c=14.
3. DIVU a=5, b=0 -> c=0xFFFF_FFFF_FFFF_FFFF at T+1. REMU a=5, b=0 -> c=5 at T+1. DIVW a=0x1_0000_0005, b=0x1_0000_0000 -> c=0xFFFF_FFFF_FFFF_FFFF at T+1 (low 32 bits of b are 0).
4. DIV a=0x8000_0000_0000_0000, b=-1 -> c=a at T+1. REMW a=0x8000_0000, b=0xFFFF_FFFF -> c=0 at T+1.
5. W ops at T+33:
   - DIVUW a=0xFFFF_FFFE, b=2 -> c=0x0000_0000_7FFF_FFFF.
   - MULW a=0x10000, b=0x8000 -> c=0xFFFF_FFFF_8000_0000.
   - DIVW a=0xFFFF_FFF9, b=2 -> c=0xFFFF_FFFF_FFFF_FFFD.
6. Control and boundary cases:
   - out_ready held 0 for 5 cycles after out_valid -> c and out_valid stable; the next request is accepted only after the handshake.
   - flush at T+10 -> out_valid never rises, in_ready=1 at T+11.
   - flush together with in_valid in IDLE -> not accepted.
   - resetn pulsed low in BUSY -> outputs return to reset values immediately, unsynchronised to clk.

Source files
------------

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative RV64M multiply/divide unit, one result bit per cycle
//            (shift-add multiply, restoring divide), single op in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [XLEN-1:0] c_MIN64 = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_MIN32 = {{(XLEN-31){1'b1}}, 31'b0};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [6:0]      r_cnt;
    logic [XLEN-1:0] r_acc;    // product accumulator / partial remainder
    logic [XLEN-1:0] r_x;      // multiplicand / divisor magnitude
    logic [XLEN-1:0] r_y;      // multiplier / dividend-quotient shift register
    logic            r_is_mul;
    logic            r_is_w;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_c;

    // ---------------- request decode ----------------
    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_w;
    logic            w_is_sgn;
    logic            w_is_rem;
    logic            w_op_ok;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;

    assign w_accept = (r_state == c_S_IDLE) && in_valid && !flush;
    assign w_is_mul = (op == OP_W'(0)) || (op == OP_W'(1));
    assign w_is_w   = (op == OP_W'(1)) || ((op >= OP_W'(6)) && (op <= OP_W'(9)));
    assign w_is_sgn = (op == OP_W'(2)) || (op == OP_W'(4)) || (op == OP_W'(6)) || (op == OP_W'(8));
    assign w_is_rem = (op == OP_W'(4)) || (op == OP_W'(5)) || (op == OP_W'(8)) || (op == OP_W'(9));
    assign w_op_ok  = (op <= OP_W'(9));

    assign w_a_ext  = !w_is_w ? a : ((w_is_sgn || w_is_mul) ? sext32(a[31:0]) : {{(XLEN-32){1'b0}}, a[31:0]});
    assign w_b_ext  = !w_is_w ? b : ((w_is_sgn || w_is_mul) ? sext32(b[31:0]) : {{(XLEN-32){1'b0}}, b[31:0]});
    assign w_a_neg  = w_is_sgn && w_a_ext[XLEN-1];
    assign w_b_neg  = w_is_sgn && w_b_ext[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_b_zero = (w_b_ext == '0);
    assign w_ovf    = w_is_sgn && (w_a_ext == (w_is_w ? c_MIN32 : c_MIN64)) && (&w_b_ext);

    // Cases resolved at accept time, without iterating.
    assign w_special = !w_op_ok || (!w_is_mul && (w_b_zero || w_ovf));

    always_comb begin
        w_spec_res = '0;
        if (w_op_ok && !w_is_mul) begin
            if (w_b_zero)
                w_spec_res = w_is_rem ? (w_is_w ? sext32(a[31:0]) : a) : '1;
            else if (w_ovf)
                w_spec_res = w_is_rem ? '0 : w_a_ext;
        end
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]   w_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_acc_nxt;
    logic [XLEN-1:0] w_x_nxt;
    logic [XLEN-1:0] w_y_nxt;

    assign w_sh   = {r_acc, r_y[XLEN-1]};
    assign w_diff = w_sh - {1'b0, r_x};
    assign w_ge   = !w_diff[XLEN];

    always_comb begin
        if (r_is_mul) begin
            w_acc_nxt = r_acc + (r_y[0] ? r_x : '0);
            w_x_nxt   = r_x << 1;
            w_y_nxt   = r_y >> 1;
        end else begin
            w_acc_nxt = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
            w_x_nxt   = r_x;
            w_y_nxt   = {r_y[XLEN-2:0], w_ge};
        end
    end

    // ---------------- result finalisation ----------------
    logic [XLEN-1:0] w_q;
    logic [XLEN-1:0] w_q_s;
    logic [XLEN-1:0] w_r_s;
    logic [XLEN-1:0] w_sel;
    logic [XLEN-1:0] w_final;

    // W dividends were pre-shifted into the top half, so the quotient lands in the low 32 bits.
    assign w_q     = r_is_w ? {{(XLEN-32){1'b0}}, w_y_nxt[31:0]} : w_y_nxt;
    assign w_q_s   = r_neg_q ? -w_q : w_q;
    assign w_r_s   = r_neg_r ? -w_acc_nxt : w_acc_nxt;
    assign w_sel   = r_is_mul ? w_acc_nxt : (r_is_rem ? w_r_s : w_q_s);
    assign w_final = r_is_w ? sext32(w_sel[31:0]) : w_sel;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= c_S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept)
                    w_state_nxt = w_special ? c_S_DONE : c_S_BUSY;
            end
            c_S_BUSY: begin
                if (r_cnt == 7'd1)
                    w_state_nxt = c_S_DONE;
            end
            c_S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
        if (flush)
            w_state_nxt = c_S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_is_mul <= 1'b0;
            r_is_w   <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_c      <= '0;
        end else if (w_accept) begin
            r_cnt    <= w_is_w ? 7'd32 : 7'd64;
            r_acc    <= '0;
            r_is_mul <= w_is_mul;
            r_is_w   <= w_is_w;
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_is_mul) begin
                r_x <= w_a_ext;
                r_y <= w_b_ext;
            end else begin
                r_x <= w_b_mag;
                r_y <= w_is_w ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
            end
            if (w_special)
                r_c <= w_spec_res;
        end else if ((r_state == c_S_BUSY) && !flush) begin
            r_cnt <= r_cnt - 7'd1;
            r_acc <= w_acc_nxt;
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            if (r_cnt == 7'd1)
                r_c <= w_final;
        end
    end

    assign c = r_c;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Self-checking bench for mdu_iter: directed cases, control
//            corner cases and randomized ops against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] c;

    int n_tests;
    int n_fail;

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_MIN  = 64'h8000_0000_0000_0000;

    mdu_iter #(.XLEN(64), .OP_W(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        longint      sx, sy, t;
        int          wx, wy, wt;
        logic [31:0] ux, uy, p;
        logic [63:0] r;
        sx = x; sy = y; wx = x[31:0]; wy = y[31:0]; ux = x[31:0]; uy = y[31:0];
        r = 64'd0;
        case (o)
            4'd0: r = x * y;
            4'd1: begin p = ux * uy; r = sx32(p); end
            4'd2, 4'd4: begin
                if (y == 64'd0)                 r = (o == 4'd2) ? c_ONES : x;
                else if (x == c_MIN && y == c_ONES) r = (o == 4'd2) ? x : 64'd0;
                else begin
                    if (o == 4'd2) t = sx / sy; else t = sx % sy;
                    r = t;
                end
            end
            4'd3: r = (y == 64'd0) ? c_ONES : x / y;
            4'd5: r = (y == 64'd0) ? x : x % y;
            4'd6, 4'd8: begin
                if (uy == 32'd0)                             r = (o == 4'd6) ? c_ONES : sx32(ux);
                else if (ux == 32'h8000_0000 && uy == 32'hFFFF_FFFF) r = (o == 4'd6) ? sx32(ux) : 64'd0;
                else begin
                    if (o == 4'd6) wt = wx / wy; else wt = wx % wy;
                    r = sx32(wt);
                end
            end
            4'd7: r = (uy == 32'd0) ? c_ONES : sx32(ux / uy);
            4'd9: r = (uy == 32'd0) ? sx32(ux) : sx32(ux % uy);
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        if (o > 4'd9) return 1;
        if (o == 4'd0) return 65;
        if (o == 4'd1) return 33;
        if (o == 4'd2 || o == 4'd3 || o == 4'd4 || o == 4'd5) begin
            if (y == 64'd0) return 1;
            if ((o == 4'd2 || o == 4'd4) && x == c_MIN && y == c_ONES) return 1;
            return 65;
        end
        if (y[31:0] == 32'd0) return 1;
        if ((o == 4'd6 || o == 4'd8) && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Issues one op; returns observed result, latency in cycles (999 on timeout)
    // and the number of sampled cycles where in_ready was high while in flight.
    task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] res, output int lat, output int rdy_hi);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; rdy_hi = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
            lat++;
        end
        if (in_ready) rdy_hi++;
        res = c;
        if (!out_valid) begin
            lat = 999;
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic retire(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b c=%h, want 1 0 0", in_ready, out_valid, c);
        end
        resetn = 1'b1;
    endtask

    task automatic test_mul();
        logic [63:0] r; int lat, rh;
        issue(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, lat, rh);
        n_tests++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB || lat !== 65) begin
            n_fail++;
            $display("FAIL mul: c=%h lat=%0d, want ffffffffffffffeb lat=65", r, lat);
        end
        n_tests++;
        if (rh !== 0) begin
            n_fail++;
            $display("FAIL mul_busy_ready: in_ready high in %0d cycles, want 0", rh);
        end
        retire(0);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_retire: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_div();
        logic [63:0] r; int lat, rh;
        issue(4'd2, -64'sd7, 64'd2, r, lat, rh);
        n_tests++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 65) begin
            n_fail++; $display("FAIL div: c=%h lat=%0d, want fffffffffffffffd lat=65", r, lat);
        end
        retire(0);
        issue(4'd4, -64'sd7, 64'd2, r, lat, rh);
        n_tests++;
        if (r !== c_ONES || lat !== 65) begin
            n_fail++; $display("FAIL rem: c=%h lat=%0d, want ffffffffffffffff lat=65", r, lat);
        end
        retire(0);
        issue(4'd3, 64'd100, 64'd7, r, lat, rh);
        n_tests++;
        if (r !== 64'd14 || lat !== 65) begin
            n_fail++; $display("FAIL divu: c=%h lat=%0d, want 14 lat=65", r, lat);
        end
        retire(0);
    endtask

    task automatic test_divzero();
        logic [63:0] r; int lat, rh;
        issue(4'd3, 64'd5, 64'd0, r, lat, rh);
        n_tests++;
        if (r !== c_ONES || lat !== 1) begin
            n_fail++; $display("FAIL divu_zero: c=%h lat=%0d, want all ones lat=1", r, lat);
        end
        retire(0);
        issue(4'd5, 64'd5, 64'd0, r, lat, rh);
        n_tests++;
        if (r !== 64'd5 || lat !== 1) begin
            n_fail++; $display("FAIL remu_zero: c=%h lat=%0d, want 5 lat=1", r, lat);
        end
        retire(0);
        issue(4'd6, 64'h1_0000_0005, 64'h1_0000_0000, r, lat, rh);
        n_tests++;
        if (r !== c_ONES || lat !== 1) begin
            n_fail++; $display("FAIL divw_zero: c=%h lat=%0d, want all ones lat=1", r, lat);
        end
        retire(0);
        issue(4'd9, 64'h0000_0000_9000_0001, 64'h7_0000_0000, r, lat, rh);
        n_tests++;
        if (r !== 64'hFFFF_FFFF_9000_0001 || lat !== 1) begin
            n_fail++; $display("FAIL remuw_zero: c=%h lat=%0d, want ffffffff90000001 lat=1", r, lat);
        end
        retire(0);
    endtask

    task automatic test_overflow();
        logic [63:0] r; int lat, rh;
        issue(4'd2, c_MIN, c_ONES, r, lat, rh);
        n_tests++;
        if (r !== c_MIN || lat !== 1) begin
            n_fail++; $display("FAIL div_ovf: c=%h lat=%0d, want 8000000000000000 lat=1", r, lat);
        end
        retire(0);
        issue(4'd8, 64'h8000_0000, 64'hFFFF_FFFF, r, lat, rh);
        n_tests++;
        if (r !== 64'd0 || lat !== 1) begin
            n_fail++; $display("FAIL remw_ovf: c=%h lat=%0d, want 0 lat=1", r, lat);
        end
        retire(0);
    endtask

    task automatic test_w();
        logic [63:0] r; int lat, rh;
        issue(4'd7, 64'hFFFF_FFFE, 64'd2, r, lat, rh);
        n_tests++;
        if (r !== 64'h0000_0000_7FFF_FFFF || lat !== 33) begin
            n_fail++; $display("FAIL divuw: c=%h lat=%0d, want 000000007fffffff lat=33", r, lat);
        end
        retire(0);
        issue(4'd1, 64'h1_0000, 64'h8000, r, lat, rh);
        n_tests++;
        if (r !== 64'hFFFF_FFFF_8000_0000 || lat !== 33) begin
            n_fail++; $display("FAIL mulw: c=%h lat=%0d, want ffffffff80000000 lat=33", r, lat);
        end
        retire(0);
        issue(4'd6, 64'hFFFF_FFF9, 64'd2, r, lat, rh);
        n_tests++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 33) begin
            n_fail++; $display("FAIL divw: c=%h lat=%0d, want fffffffffffffffd lat=33", r, lat);
        end
        retire(0);
    endtask

    task automatic test_backpressure();
        logic [63:0] r; int lat, rh; int bad;
        issue(4'd3, 64'd100, 64'd7, r, lat, rh);
        op = 4'd3; a = 64'd1; b = 64'd0; in_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || c !== 64'd14 || in_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || c !== c_ONES) begin
            n_fail++; $display("FAIL hold_next_req: out_valid=%b c=%h, want 1 all ones", out_valid, c);
        end
        retire(0);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        op = 4'd0; a = 64'd9; b = 64'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_busy: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_no_result: out_valid high %0d cycles, want 0", seen);
        end
        // flush alongside a request in IDLE
        op = 4'd3; a = 64'd1; b = 64'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] r; int lat, rh;
        issue(4'd3, 64'd5, 64'd0, r, lat, rh);
        retire(0);
        @(negedge clk);
        op = 4'd0; a = 64'd3; b = 64'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b c=%h, want 1 0 0", in_ready, out_valid, c);
        end
        @(negedge clk);
        resetn = 1'b1;
        issue(4'd0, 64'd3, 64'd5, r, lat, rh);
        n_tests++;
        if (r !== 64'd15 || lat !== 65) begin
            n_fail++; $display("FAIL after_reset: c=%h lat=%0d, want 15 lat=65", r, lat);
        end
        retire(0);
    endtask

    task automatic test_random();
        logic [63:0] r, x, y, er; logic [3:0] o; int lat, rh, el;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ;
                1: begin x = 64'($urandom_range(0, 1000)); y = 64'($urandom_range(1, 50)); end
                2: y = {32'($urandom), 32'd0} & ((o >= 4'd6) ? c_ONES : 64'd0);
                3: begin x = c_MIN; y = c_ONES; end
                4: begin x = {32'($urandom), 32'h8000_0000}; y = {32'($urandom), 32'hFFFF_FFFF}; end
                default: begin x = -64'($urandom_range(1, 5000)); y = 64'($urandom_range(1, 30)); end
            endcase
            er = ref_res(o, x, y);
            el = ref_lat(o, x, y);
            issue(o, x, y, r, lat, rh);
            n_tests++;
            if (r !== er || lat !== el) begin
                n_fail++;
                $display("FAIL random op=%0d a=%h b=%h: c=%h lat=%0d, want %h lat=%0d", o, x, y, r, lat, er, el);
            end
            retire($urandom_range(0, 3));
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        resetn = 1'b0; in_valid = 1'b0; op = 4'd0; a = 64'd0; b = 64'd0;
        flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_overflow();
        test_w();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
